// File: rtl/hum_fan_ctrl.sv
// hum_fan_ctrl: qualifies DHT11 humidity tens-digit samples, debounces the
// humidity band, soft-ramps the PWM compare value toward the band target and
// forces the fan off when sensor data goes stale.
// Optional feature macro: HUM_FAN_BOOST_EN (adds boost_req, target = PERIOD).
module hum_fan_ctrl #(
    parameter int unsigned PERIOD      = 999,
    parameter int unsigned STEP        = 10,
    parameter int unsigned RAMP_DIV    = 1000,
    parameter int unsigned STALE_TICKS = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [3:0] humidity10,
`ifdef HUM_FAN_BOOST_EN
    input  logic       boost_req,
`endif
    output logic [9:0] duty_cycle,
    output logic       fan_on,
    output logic       busy,
    output logic       fault,
    output logic [1:0] band
);

    localparam int unsigned DUTY_W  = 10;
    localparam int unsigned SUM_W   = DUTY_W + 1;
    localparam int unsigned CNT_W   = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned STALE_W = $clog2(STALE_TICKS + 1);

    localparam logic [DUTY_W-1:0] TGT_B0   = DUTY_W'((PERIOD * 80) / 100);
    localparam logic [DUTY_W-1:0] TGT_B1   = DUTY_W'((PERIOD * 50) / 100);
    localparam logic [DUTY_W-1:0] TGT_B2   = DUTY_W'((PERIOD * 20) / 100);
    localparam logic [DUTY_W-1:0] TGT_B3   = DUTY_W'(0);
    localparam logic [DUTY_W-1:0] TGT_MAX  = DUTY_W'(PERIOD);
    localparam logic [SUM_W-1:0]  STEP_W   = SUM_W'(STEP);
    localparam logic [CNT_W-1:0]  TICK_END = CNT_W'(RAMP_DIV - 1);
    localparam logic [STALE_W-1:0] STALE_END = STALE_W'(STALE_TICKS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_RAMP_UP,
        ST_RAMP_DOWN,
        ST_FAULT
    } state_t;

    state_t              state_q,    state_d;
    logic [DUTY_W-1:0]   duty_q,     duty_d;
    logic [1:0]          band_q,     band_d;
    logic [1:0]          cand_q,     cand_d;
    logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [STALE_W-1:0]  stale_q,    stale_d;
    logic                fan_on_q,   fan_on_d;
    logic                busy_q,     busy_d;
    logic                fault_q,    fault_d;

    logic                tick_c;
    logic                sample_ok_c;
    logic [1:0]          mapped_c;
    logic                boost_c;
    logic [DUTY_W-1:0]   target_c;
    logic [DUTY_W-1:0]   target_next_c;
    logic [SUM_W-1:0]    duty_ext_c;
    logic [SUM_W-1:0]    tgt_ext_c;
    logic [SUM_W-1:0]    sum_c;
    logic [STALE_W-1:0]  stale_inc_c;
    logic                expire_c;

    // Humidity tens digit to band: 0-1 wettest demand, 8-9 none.
    function automatic logic [1:0] band_of(input logic [3:0] h);
        logic [1:0] b;
        if (h <= 4'd1)      b = 2'd0;
        else if (h <= 4'd4) b = 2'd1;
        else if (h <= 4'd7) b = 2'd2;
        else                b = 2'd3;
        return b;
    endfunction

    // Duty target for a band, overridden to full scale by boost.
    function automatic logic [DUTY_W-1:0] target_of(input logic [1:0] b, input logic bst);
        logic [DUTY_W-1:0] t;
        case (b)
            2'd0:    t = TGT_B0;
            2'd1:    t = TGT_B1;
            2'd2:    t = TGT_B2;
            default: t = TGT_B3;
        endcase
        if (bst) t = TGT_MAX;
        return t;
    endfunction

    // Steady-state classification from a duty/target pair.
    function automatic state_t classify(input logic [DUTY_W-1:0] d, input logic [DUTY_W-1:0] t);
        state_t s;
        if (d < t)           s = ST_RAMP_UP;
        else if (d > t)      s = ST_RAMP_DOWN;
        else if (d == '0)    s = ST_IDLE;
        else                 s = ST_HOLD;
        return s;
    endfunction

`ifdef HUM_FAN_BOOST_EN
    assign boost_c = boost_req;
`else
    assign boost_c = 1'b0;
`endif

    // Sample qualification and tick decode.
    always_comb begin
        tick_c      = (tick_cnt_q == TICK_END);
        sample_ok_c = sample_valid && (humidity10 <= 4'd9);
        mapped_c    = band_of(humidity10);
        target_c    = target_of(band_q, boost_c && (state_q != ST_FAULT));
        duty_ext_c  = {1'b0, duty_q};
        tgt_ext_c   = {1'b0, target_c};
        sum_c       = duty_ext_c + STEP_W;
        stale_inc_c = stale_q + STALE_W'(1);
        expire_c    = tick_c && (stale_inc_c == STALE_END) && !sample_ok_c;
    end

    // Next-state: tick counter, ramp, debounce, staleness and FAULT handling.
    always_comb begin
        state_d       = state_q;
        duty_d        = duty_q;
        band_d        = band_q;
        cand_d        = cand_q;
        stale_d       = stale_q;
        tick_cnt_d    = tick_c ? '0 : tick_cnt_q + CNT_W'(1);
        target_next_c = target_c;

        if (state_q == ST_FAULT) begin
            // Fan stays off; only a valid sample restarts normal operation.
            if (sample_ok_c) begin
                cand_d  = mapped_c;
                stale_d = '0;
            end
        end else begin
            if (tick_c) begin
                stale_d = stale_inc_c;
                if (duty_q < target_c) begin
                    duty_d = (sum_c >= tgt_ext_c) ? target_c : sum_c[DUTY_W-1:0];
                end else if (duty_q > target_c) begin
                    duty_d = (duty_ext_c >= tgt_ext_c + STEP_W)
                           ? duty_q - DUTY_W'(STEP) : target_c;
                end
            end
            if (sample_ok_c) begin
                stale_d = '0;
                if (mapped_c == cand_q) band_d = cand_q;
                else                    cand_d = mapped_c;
            end else if (expire_c) begin
                duty_d  = '0;
                band_d  = 2'd3;
                cand_d  = 2'd3;
                stale_d = '0;
            end
        end

        target_next_c = target_of(band_d, boost_c);
        if (expire_c || (state_q == ST_FAULT && !sample_ok_c)) begin
            state_d = ST_FAULT;
        end else begin
            state_d = classify(duty_d, target_next_c);
        end

        fan_on_d = (duty_d != '0);
        busy_d   = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
        fault_d  = (state_d == ST_FAULT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            duty_q     <= '0;
            band_q     <= 2'd3;
            cand_q     <= 2'd3;
            tick_cnt_q <= '0;
            stale_q    <= '0;
            fan_on_q   <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            band_q     <= band_d;
            cand_q     <= cand_d;
            tick_cnt_q <= tick_cnt_d;
            stale_q    <= stale_d;
            fan_on_q   <= fan_on_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
        end
    end

    assign duty_cycle = duty_q;
    assign band       = band_q;
    assign fan_on     = fan_on_q;
    assign busy       = busy_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_hum_fan_ctrl.sv
// Bench for hum_fan_ctrl: vector table, directed corner sequences and random
// stimulus against a behavioural model (RAMP_DIV=4, STEP=100, STALE_TICKS=8).
module tb_hum_fan_ctrl;

    localparam int P     = 999;
    localparam int STEP  = 100;
    localparam int RDIV  = 4;
    localparam int STALE = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic [3:0] humidity10;
    logic [9:0] duty_cycle;
    logic       fan_on, busy, fault;
    logic [1:0] band;
`ifdef HUM_FAN_BOOST_EN
    logic       boost_req = 1'b0;
`endif

    hum_fan_ctrl #(.PERIOD(P), .STEP(STEP), .RAMP_DIV(RDIV), .STALE_TICKS(STALE)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .humidity10(humidity10),
`ifdef HUM_FAN_BOOST_EN
        .boost_req(boost_req),
`endif
        .duty_cycle(duty_cycle), .fan_on(fan_on), .busy(busy), .fault(fault), .band(band)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int m_duty, m_band, m_cand, m_cnt, m_stale;
    bit m_fault;

    function automatic int tgt(input int b);
        case (b)
            0: return (P * 80) / 100;
            1: return (P * 50) / 100;
            2: return (P * 20) / 100;
            default: return 0;
        endcase
    endfunction

    function automatic int bmap(input int h);
        if (h <= 1) return 0;
        if (h <= 4) return 1;
        if (h <= 7) return 2;
        return 3;
    endfunction

    task automatic model_step(input bit r, input bit v, input int h);
        bit tick;
        bit ok;
        int t;
        if (r) begin
            m_duty = 0; m_band = 3; m_cand = 3; m_cnt = 0; m_stale = 0; m_fault = 0;
            return;
        end
        tick  = (m_cnt == RDIV - 1);
        m_cnt = (m_cnt + 1) % RDIV;
        ok    = v && (h <= 9);
        if (m_fault) begin
            if (ok) begin
                m_fault = 0; m_cand = bmap(h); m_stale = 0;
            end
            return;
        end
        t = tgt(m_band);
        if (tick) begin
            if (m_duty < t)      m_duty = (m_duty + STEP > t) ? t : m_duty + STEP;
            else if (m_duty > t) m_duty = (m_duty - STEP < t) ? t : m_duty - STEP;
            m_stale++;
        end
        if (ok) begin
            m_stale = 0;
            if (bmap(h) == m_cand) m_band = m_cand;
            else                   m_cand = bmap(h);
        end else if (m_stale >= STALE) begin
            m_fault = 1; m_duty = 0; m_band = 3; m_cand = 3; m_stale = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("duty",  int'(duty_cycle), m_duty);
        check("band",  int'(band),       m_band);
        check("fan_on", int'(fan_on),    int'(m_duty != 0));
        check("busy",  int'(busy),       int'(!m_fault && m_duty != tgt(m_band)));
        check("fault", int'(fault),      int'(m_fault));
    endtask

    // One clock: drive inputs, clock edge, advance model, settle at negedge.
    task automatic cyc(input bit r, input bit v, input int h);
        rst = r; sample_valid = v; humidity10 = 4'(h);
        @(posedge clk);
        model_step(r, v, h);
        @(negedge clk);
    endtask

    // Run until model duty reaches goal, with periodic keep-alive samples.
    task automatic run_to(input int goal, input int keep_h, input string name);
        int n = 0;
        while (m_duty != goal && n < 200) begin
            cyc(0, (n % 6) == 5, keep_h);
            check_model();
            n++;
        end
        if (m_duty != goal) check({name, "_timeout"}, n, 0);
    endtask

    typedef struct {
        bit r; bit v; int h;
        int duty; int band; bit fan; bit busy; bit fault;
    } vec_t;

    vec_t vec [10];

    initial begin
        // Reset, first commit and first ramp steps from the test plan.
        vec[0] = '{1, 0, 0,   0, 3, 0, 0, 0};
        vec[1] = '{1, 0, 0,   0, 3, 0, 0, 0};
        vec[2] = '{0, 1, 1,   0, 3, 0, 0, 0};
        vec[3] = '{0, 1, 1,   0, 0, 0, 1, 0};
        vec[4] = '{0, 0, 0,   0, 0, 0, 1, 0};
        vec[5] = '{0, 0, 0, 100, 0, 1, 1, 0};
        vec[6] = '{0, 0, 0, 100, 0, 1, 1, 0};
        vec[7] = '{0, 0, 0, 100, 0, 1, 1, 0};
        vec[8] = '{0, 0, 0, 100, 0, 1, 1, 0};
        vec[9] = '{0, 0, 0, 200, 0, 1, 1, 0};

        rst = 1'b1; sample_valid = 1'b0; humidity10 = 4'd0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            cyc(vec[i].r, vec[i].v, vec[i].h);
            check($sformatf("vec%0d_duty", i),  int'(duty_cycle), vec[i].duty);
            check($sformatf("vec%0d_band", i),  int'(band),       vec[i].band);
            check($sformatf("vec%0d_fan", i),   int'(fan_on),     int'(vec[i].fan));
            check($sformatf("vec%0d_busy", i),  int'(busy),       int'(vec[i].busy));
            check($sformatf("vec%0d_fault", i), int'(fault),      int'(vec[i].fault));
        end

        // Ramp to 799, then HOLD.
        run_to(799, 1, "ramp_up");
        cyc(0, 0, 0); cyc(0, 0, 0);
        check("hold_duty", int'(duty_cycle), 799);
        check("hold_busy", int'(busy), 0);

        // Non-repeating samples do not commit; invalid digits are ignored.
        cyc(0, 1, 5); cyc(0, 1, 1);
        check("no_commit_band", int'(band), 0);
        cyc(0, 1, 5); cyc(0, 1, 12); cyc(0, 1, 12); check_model();
        cyc(0, 1, 5);
        check("invalid_skip_band", int'(band), 2);
        check_model();
        cyc(0, 1, 1); cyc(0, 1, 1);
        run_to(799, 1, "ramp_back");

        // Ramp down to off.
        cyc(0, 1, 8); cyc(0, 1, 8);
        run_to(0, 8, "ramp_down");
        cyc(0, 0, 0);
        check("off_duty", int'(duty_cycle), 0);
        check("off_fan", int'(fan_on), 0);
        check("off_busy", int'(busy), 0);

        // Stale expiry at duty 499.
        cyc(0, 1, 3); cyc(0, 1, 3);
        run_to(499, 3, "ramp_499");
        begin
            int n = 0;
            while (!m_fault && n < 80) begin
                cyc(0, 0, 0); check_model(); n++;
            end
            if (!m_fault) check("stale_timeout", n, 0);
        end
        check("fault_set", int'(fault), 1);
        check("fault_duty", int'(duty_cycle), 0);
        check("fault_band", int'(band), 3);
        cyc(0, 1, 12);
        check("fault_invalid_kept", int'(fault), 1);
        cyc(0, 1, 3);
        check("fault_exit", int'(fault), 0);

        // Sample coincident with stale expiry prevents FAULT.
        begin
            int n = 0;
            while (!(m_stale == STALE - 1 && m_cnt == RDIV - 1) && n < 80) begin
                cyc(0, 0, 0); n++;
            end
            if (n >= 80) check("coincide_timeout", n, 0);
        end
        cyc(0, 1, 3);
        check("coincide_no_fault", int'(fault), 0);
        check_model();

        // Reset mid-ramp at duty 300.
        cyc(0, 1, 1); cyc(0, 1, 1);
        run_to(300, 1, "ramp_300");
        cyc(1, 0, 0);
        check("rst_duty", int'(duty_cycle), 0);
        check("rst_band", int'(band), 3);
        check("rst_fan", int'(fan_on), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fault", int'(fault), 0);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, v;
            int h;
            r = ($urandom % 500) == 0;
            v = ($urandom % 9) == 0;
            h = int'($urandom % 16);
            if (($urandom % 3) != 0 && h > 9) h = h - 10;
            cyc(r, v, h);
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
